// File: rtl/tri_channel_ctrl.sv
// tri_channel_ctrl: triangle channel registers, period timer, linear/length counters and sequencer step strobe
module tri_channel_ctrl #(
  parameter bit ULTRASONIC_MUTE = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cpu_en,
  input  logic       reg_wr,
  input  logic [1:0] reg_addr,
  input  logic [7:0] reg_wdata,
  input  logic       chan_enable,
  input  logic       quarter_frame,
  input  logic       half_frame,
  output logic       next_step,
  output logic       length_active
);
  localparam logic [7:0] LEN_TBL [32] = '{
    8'd10, 8'd254, 8'd20, 8'd2, 8'd40, 8'd4, 8'd80, 8'd6,
    8'd160, 8'd8, 8'd60, 8'd10, 8'd14, 8'd12, 8'd26, 8'd14,
    8'd12, 8'd16, 8'd24, 8'd18, 8'd48, 8'd20, 8'd96, 8'd22,
    8'd192, 8'd24, 8'd72, 8'd26, 8'd16, 8'd28, 8'd32, 8'd30
  };
  logic [10:0] timer_q, timer_d, period_q, period_d;
  logic [6:0]  linear_q, linear_d, lin_reload_val_q, lin_reload_val_d;
  logic [7:0]  length_q, length_d;
  logic        ctrl_q, ctrl_d, lin_reload_flag_q, lin_reload_flag_d;
  logic        wr_lin, wr_lo, wr_hi, qf, hf;
  // next state: frame clocks see pre-write ctrl/reload value, a $400B load beats a same-cycle decrement
  always_comb begin
    wr_lin = cpu_en & reg_wr & (reg_addr == 2'd0);
    wr_lo = cpu_en & reg_wr & (reg_addr == 2'd2);
    wr_hi = cpu_en & reg_wr & (reg_addr == 2'd3);
    qf = cpu_en & quarter_frame;
    hf = cpu_en & half_frame;
    timer_d = !cpu_en ? timer_q : (timer_q == '0 ? period_q : timer_q - 11'd1);
    ctrl_d = wr_lin ? reg_wdata[7] : ctrl_q;
    lin_reload_val_d = wr_lin ? reg_wdata[6:0] : lin_reload_val_q;
    period_d = {wr_hi ? reg_wdata[2:0] : period_q[10:8], wr_lo ? reg_wdata : period_q[7:0]};
    linear_d = !qf ? linear_q : lin_reload_flag_q ? lin_reload_val_q : linear_q - {6'd0, linear_q != '0};
    lin_reload_flag_d = wr_hi | (lin_reload_flag_q & !(qf & !ctrl_q));
    length_d = !cpu_en ? length_q :
               !chan_enable ? '0 :
               wr_hi ? LEN_TBL[reg_wdata[7:3]] :
               length_q - {7'd0, hf & !ctrl_q & (length_q != '0)};
  end
  assign next_step = cpu_en & (timer_q == '0) & (linear_q != '0) & (length_q != '0) &
                     !(ULTRASONIC_MUTE && period_q < 11'd2);
  assign length_active = length_q != '0;
  // state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      timer_q <= '0;
      period_q <= '0;
      linear_q <= '0;
      lin_reload_val_q <= '0;
      lin_reload_flag_q <= 1'b0;
      ctrl_q <= 1'b0;
      length_q <= '0;
    end else begin
      timer_q <= timer_d;
      period_q <= period_d;
      linear_q <= linear_d;
      lin_reload_val_q <= lin_reload_val_d;
      lin_reload_flag_q <= lin_reload_flag_d;
      ctrl_q <= ctrl_d;
      length_q <= length_d;
    end
  end
endmodule
